// File: rtl/conv_pkg.sv
// Shared definitions for the convolution accelerator's feature-map address logic.
// Default widths are common to the write-side and read-side address generators.
package conv_pkg;

    localparam int CONV_DIMW  = 6;
    localparam int CONV_ADDRW = 12;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } rd_state_t;

endpackage

// File: rtl/counter_with_clr.sv
// Up-counter with synchronous clear; clear wins over increment.
module counter_with_clr #(
    parameter int OUTW = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            incr,
    output logic [OUTW-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (incr)
            count <= count + OUTW'(1);
    end

endmodule

// File: rtl/conv_window_addr_reader.sv
// Reads an N x N raster feature map back as sliding K x K windows, emitting one
// read address per handshake, output pixels in raster order.
module conv_window_addr_reader
    import conv_pkg::*;
#(
    parameter int DIMW  = CONV_DIMW,
    parameter int ADDRW = CONV_ADDRW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIMW-1:0]  n_dim,
    input  logic [DIMW-1:0]  k_dim,
    output logic [ADDRW-1:0] addr_out,
    output logic             addr_valid,
    input  logic             addr_ready,
    output logic             last_in_window,
    output logic             last_in_frame,
    output logic             busy,
    output logic             done
);

    rd_state_t state, state_nxt;

    logic [DIMW-1:0] n_lat, k_lat;
    logic [DIMW-1:0] kc, kr, oc, orow;
    logic [DIMW-1:0] k_max, o_max;
    logic            start_acc, cfg_ok, hs;
    logic            kc_wrap, kr_wrap, oc_wrap;
    logic [ADDRW-1:0] row, col;

    assign start_acc = (state == IDLE) && start;
    assign cfg_ok    = (k_dim != '0) && (n_dim != '0) && (k_dim <= n_dim);
    assign hs        = addr_valid && addr_ready;

    assign k_max   = k_lat - DIMW'(1);
    assign o_max   = n_lat - k_lat;
    assign kc_wrap = (kc == k_max);
    assign kr_wrap = (kr == k_max);
    assign oc_wrap = (oc == o_max);

    always_ff @(posedge clk) begin
        if (reset) begin
            n_lat <= '0;
            k_lat <= '0;
        end else if (start_acc) begin
            n_lat <= n_dim;
            k_lat <= k_dim;
        end
    end

    // Innermost first: kc, kr, oc, orow. Each wraps on its own terminal count
    // only when every inner loop wraps in the same handshake.
    counter_with_clr #(.OUTW(DIMW)) u_kc (
        .clk   (clk),
        .reset (reset),
        .clr   (start_acc || (hs && kc_wrap)),
        .incr  (hs),
        .count (kc)
    );

    counter_with_clr #(.OUTW(DIMW)) u_kr (
        .clk   (clk),
        .reset (reset),
        .clr   (start_acc || (hs && kc_wrap && kr_wrap)),
        .incr  (hs && kc_wrap),
        .count (kr)
    );

    counter_with_clr #(.OUTW(DIMW)) u_oc (
        .clk   (clk),
        .reset (reset),
        .clr   (start_acc || (hs && kc_wrap && kr_wrap && oc_wrap)),
        .incr  (hs && kc_wrap && kr_wrap),
        .count (oc)
    );

    counter_with_clr #(.OUTW(DIMW)) u_or (
        .clk   (clk),
        .reset (reset),
        .clr   (start_acc || (hs && last_in_frame)),
        .incr  (hs && kc_wrap && kr_wrap && oc_wrap),
        .count (orow)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = cfg_ok ? RUN : DONE;
            RUN:  if (hs && last_in_frame) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        addr_valid     = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        last_in_window = 1'b0;
        last_in_frame  = 1'b0;
        case (state)
            RUN: begin
                addr_valid     = 1'b1;
                busy           = 1'b1;
                last_in_window = kr_wrap && kc_wrap;
                last_in_frame  = kr_wrap && kc_wrap && (orow == o_max) && oc_wrap;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered counters only, so addr_ready never reaches the address path.
    always_comb begin
        row      = ADDRW'(orow) + ADDRW'(kr);
        col      = ADDRW'(oc) + ADDRW'(kc);
        addr_out = row * ADDRW'(n_lat) + col;
    end

endmodule

// File: tb/tb_conv_window_addr_reader.sv
// Directed self-checking bench for the sliding-window read address generator.
module tb_conv_window_addr_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  n_dim, k_dim;
    logic [11:0] addr_out;
    logic        addr_valid, addr_ready;
    logic        last_in_window, last_in_frame, busy, done;

    int checks = 0;
    int errors = 0;

    conv_window_addr_reader dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .n_dim          (n_dim),
        .k_dim          (k_dim),
        .addr_out       (addr_out),
        .addr_valid     (addr_valid),
        .addr_ready     (addr_ready),
        .last_in_window (last_in_window),
        .last_in_frame  (last_in_frame),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic b, input logic d,
                              input logic lw, input logic lf, input int a);
        check({tag, " addr_valid"}, 32'(addr_valid), 32'(v));
        check({tag, " busy"}, 32'(busy), 32'(b));
        check({tag, " done"}, 32'(done), 32'(d));
        check({tag, " last_in_window"}, 32'(last_in_window), 32'(lw));
        check({tag, " last_in_frame"}, 32'(last_in_frame), 32'(lf));
        check({tag, " addr_out"}, 32'(addr_out), 32'(a));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_3x2 [16] = '{0, 1, 3, 4,  1, 2, 4, 5,  3, 4, 6, 7,  4, 5, 7, 8};
    int exp_4x3 [10] = '{0, 1, 2, 4, 5, 6, 8, 9, 10, 1};
    bit rdy_pat [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int h;
        int cyc;
        reset      = 1'b1;
        start      = 1'b0;
        n_dim      = '0;
        k_dim      = '0;
        addr_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        expect_out("reset", 0, 0, 0, 0, 0, 0);

        // Basic frame N=3 K=2, start in cycle 0.
        start = 1'b1; n_dim = 6'd3; k_dim = 6'd2;
        for (int i = 0; i < 16; i++) begin
            tick();
            start = 1'b0;
            expect_out($sformatf("basic[%0d]", i), 1, 1, 0, (i % 4) == 3, i == 15, exp_3x2[i]);
        end
        tick();
        expect_out("basic done", 0, 1, 1, 0, 0, 0);
        tick();
        expect_out("basic idle", 0, 0, 0, 0, 0, 0);

        // Backpressure with ready pattern 1,0,0,1 repeating.
        start = 1'b1; n_dim = 6'd3; k_dim = 6'd2;
        tick();
        start = 1'b0;
        h   = 0;
        cyc = 0;
        while (h < 16 && cyc < 100) begin
            addr_ready = rdy_pat[cyc % 4];
            expect_out($sformatf("bp[%0d]", h), 1, 1, 0, (h % 4) == 3, h == 15, exp_3x2[h]);
            if (addr_ready) h++;
            cyc++;
            tick();
        end
        check("bp handshakes within budget", 32'(h), 32'd16);
        addr_ready = 1'b1;
        expect_out("bp done", 0, 1, 1, 0, 0, 0);
        tick();
        expect_out("bp idle", 0, 0, 0, 0, 0, 0);

        // K = N = 3: one window.
        start = 1'b1; n_dim = 6'd3; k_dim = 6'd3;
        for (int i = 0; i < 9; i++) begin
            tick();
            start = 1'b0;
            expect_out($sformatf("k3n3[%0d]", i), 1, 1, 0, i == 8, i == 8, i);
        end
        tick();
        expect_out("k3n3 done", 0, 1, 1, 0, 0, 0);
        tick();
        expect_out("k3n3 idle", 0, 0, 0, 0, 0, 0);

        // Invalid configs go straight to DONE.
        start = 1'b1; n_dim = 6'd3; k_dim = 6'd4;
        tick();
        start = 1'b0;
        expect_out("k4n3 done", 0, 1, 1, 0, 0, 0);
        tick();
        expect_out("k4n3 idle", 0, 0, 0, 0, 0, 0);
        start = 1'b1; n_dim = 6'd5; k_dim = 6'd0;
        tick();
        start = 1'b0;
        expect_out("k0n5 done", 0, 1, 1, 0, 0, 0);
        tick();
        expect_out("k0n5 idle", 0, 0, 0, 0, 0, 0);

        // N=4 K=3 with a start pulse mid-frame, then reset at the 10th address.
        start = 1'b1; n_dim = 6'd4; k_dim = 6'd3;
        for (int i = 0; i < 10; i++) begin
            tick();
            start = 1'b0;
            expect_out($sformatf("n4k3[%0d]", i), 1, 1, 0, i == 8, 0, exp_4x3[i]);
            if (i == 2) begin
                start = 1'b1;
                n_dim = 6'd8;
            end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_out("mid reset", 0, 0, 0, 0, 0, 0);
        tick();
        expect_out("post reset no done", 0, 0, 0, 0, 0, 0);

        start = 1'b1; n_dim = 6'd4; k_dim = 6'd3;
        for (int i = 0; i < 4; i++) begin
            tick();
            start = 1'b0;
            expect_out($sformatf("restart[%0d]", i), 1, 1, 0, 0, 0, exp_4x3[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
